seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 207 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops, shift-add multiply, optional restoring divide.
// Define SEQ_ALU_DIV_EN to build the DIVU (1100) datapath and the DIV state.
module seq_alu #(
    parameter int D_WIDTH    = 32,
    parameter int OP_WIDTH   = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   ALUOpsel,
    input  logic [D_WIDTH-1:0]    opA,
    input  logic [D_WIDTH-1:0]    opB,
    input  logic [ADDR_WIDTH-1:0] opaddrA,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [D_WIDTH-1:0]    ALUResult,
    output logic [D_WIDTH-1:0]    ALUResultHi,
    output logic                  cout,
    output logic                  zero,
    output logic                  ovf,
    output logic [1:0]            dbgState
);

    localparam int SH_W  = $clog2(D_WIDTH);
    localparam int CNT_W = $clog2(D_WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(4'h0);
    localparam logic [OP_WIDTH-1:0] OP_PASSA = OP_WIDTH'(4'h2);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(4'h3);
    localparam logic [OP_WIDTH-1:0] OP_ADDR0 = OP_WIDTH'(4'h4);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(4'h5);
    localparam logic [OP_WIDTH-1:0] OP_ADDR1 = OP_WIDTH'(4'h6);
    localparam logic [OP_WIDTH-1:0] OP_MULU  = OP_WIDTH'(4'h7);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(4'h8);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(4'h9);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(4'hA);
    localparam logic [OP_WIDTH-1:0] OP_NOTA  = OP_WIDTH'(4'hB);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(4'hD);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(4'hE);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(4'hF);

`ifdef SEQ_ALU_DIV_EN
    localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(4'hC);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   iterCnt;
    logic [D_WIDTH-1:0] accHi;
    logic [D_WIDTH-1:0] accLo;
    logic [D_WIDTH-1:0] opReg;

    // Handshake: a request transfers on a rising edge with in_valid && in_ready,
    // a result transfers with out_valid && out_ready; a stalled result holds all outputs.
    logic accept;
    logic lastIter;
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign lastIter = (iterCnt == CNT_W'(D_WIDTH - 1));
    assign dbgState = state;

    logic [D_WIDTH:0]   addFull;
    logic [D_WIDTH:0]   subFull;
    logic [SH_W-1:0]    shAmt;
    logic [D_WIDTH-1:0] scRes;
    logic               scCout;
    logic               scOvf;

    assign addFull = {1'b0, opA} + {1'b0, opB};
    assign subFull = {1'b0, opA} - {1'b0, opB};
    assign shAmt   = opB[SH_W-1:0];

    always_comb begin
        scRes  = '0;
        scCout = 1'b0;
        scOvf  = 1'b0;
        case (ALUOpsel)
            OP_ADD: begin
                scRes  = addFull[D_WIDTH-1:0];
                scCout = addFull[D_WIDTH];
                scOvf  = (opA[D_WIDTH-1] == opB[D_WIDTH-1]) && (addFull[D_WIDTH-1] != opA[D_WIDTH-1]);
            end
            OP_SUB: begin
                scRes  = subFull[D_WIDTH-1:0];
                scCout = subFull[D_WIDTH];
                scOvf  = (opA[D_WIDTH-1] != opB[D_WIDTH-1]) && (subFull[D_WIDTH-1] != opA[D_WIDTH-1]);
            end
            OP_AND:   scRes = opA & opB;
            OP_OR:    scRes = opA | opB;
            OP_XOR:   scRes = opA ^ opB;
            OP_NOTA:  scRes = ~opA;
            OP_SLL:   scRes = opA << shAmt;
            OP_SRL:   scRes = opA >> shAmt;
            OP_SRA:   scRes = $signed(opA) >>> shAmt;
            OP_PASSA: scRes = opA;
            OP_ADDR0, OP_ADDR1: scRes = D_WIDTH'(opaddrA);
            OP_SLT:   scRes = {{(D_WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
            default:  scRes = '0;
        endcase
    end

    // Shift-add step: accLo holds the remaining multiplier bits, product shifts in from the top.
    logic [D_WIDTH:0]   mulSum;
    logic [D_WIDTH-1:0] mulHiNext;
    logic [D_WIDTH-1:0] mulLoNext;
    assign mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, opReg} : {(D_WIDTH+1){1'b0}});
    assign mulHiNext = mulSum[D_WIDTH:1];
    assign mulLoNext = {mulSum[0], accLo[D_WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    // Restoring step: a zero divisor never borrows, giving all-ones quotient and remainder = opA.
    logic [D_WIDTH:0]   divShift;
    logic [D_WIDTH:0]   divDiff;
    logic [D_WIDTH-1:0] divRemNext;
    logic [D_WIDTH-1:0] divQuoNext;
    assign divShift   = {accHi, accLo[D_WIDTH-1]};
    assign divDiff    = divShift - {1'b0, opReg};
    assign divRemNext = divDiff[D_WIDTH] ? divShift[D_WIDTH-1:0] : divDiff[D_WIDTH-1:0];
    assign divQuoNext = {accLo[D_WIDTH-2:0], ~divDiff[D_WIDTH]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            iterCnt     <= '0;
            accHi       <= '0;
            accLo       <= '0;
            opReg       <= '0;
            out_valid   <= 1'b0;
            ALUResult   <= '0;
            ALUResultHi <= '0;
            cout        <= 1'b0;
            zero        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (ALUOpsel == OP_MULU) begin
                            state   <= MUL;
                            iterCnt <= '0;
                            accHi   <= '0;
                            accLo   <= opB;
                            opReg   <= opA;
`ifdef SEQ_ALU_DIV_EN
                        end else if (ALUOpsel == OP_DIVU) begin
                            state   <= DIV;
                            iterCnt <= '0;
                            accHi   <= '0;
                            accLo   <= opA;
                            opReg   <= opB;
`endif
                        end else begin
                            out_valid   <= 1'b1;
                            ALUResult   <= scRes;
                            ALUResultHi <= '0;
                            cout        <= scCout;
                            zero        <= (scRes == '0);
                            ovf         <= scOvf;
                        end
                    end
                end
                MUL: begin
                    accHi   <= mulHiNext;
                    accLo   <= mulLoNext;
                    iterCnt <= iterCnt + 1'b1;
                    if (lastIter) begin
                        state       <= IDLE;
                        iterCnt     <= '0;
                        out_valid   <= 1'b1;
                        ALUResult   <= mulLoNext;
                        ALUResultHi <= mulHiNext;
                        cout        <= 1'b0;
                        zero        <= (mulLoNext == '0);
                        ovf         <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV: begin
                    accHi   <= divRemNext;
                    accLo   <= divQuoNext;
                    iterCnt <= iterCnt + 1'b1;
                    if (lastIter) begin
                        state       <= IDLE;
                        iterCnt     <= '0;
                        out_valid   <= 1'b1;
                        ALUResult   <= divQuoNext;
                        ALUResultHi <= divRemNext;
                        cout        <= 1'b0;
                        zero        <= (divQuoNext == '0);
                        ovf         <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu; covers the SEQ_ALU_DIV_EN build when that macro is defined.
module tb_seq_alu;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int AW = 6;
    localparam int RW = 2 * DW + 4;

    localparam logic [OW-1:0] OP_ADD   = 4'h0;
    localparam logic [OW-1:0] OP_UNDEF = 4'h1;
    localparam logic [OW-1:0] OP_PASSA = 4'h2;
    localparam logic [OW-1:0] OP_SUB   = 4'h3;
    localparam logic [OW-1:0] OP_ADDR0 = 4'h4;
    localparam logic [OW-1:0] OP_SLT   = 4'h5;
    localparam logic [OW-1:0] OP_ADDR1 = 4'h6;
    localparam logic [OW-1:0] OP_MULU  = 4'h7;
    localparam logic [OW-1:0] OP_AND   = 4'h8;
    localparam logic [OW-1:0] OP_OR    = 4'h9;
    localparam logic [OW-1:0] OP_XOR   = 4'hA;
    localparam logic [OW-1:0] OP_NOTA  = 4'hB;
    localparam logic [OW-1:0] OP_DIVU  = 4'hC;
    localparam logic [OW-1:0] OP_SLL   = 4'hD;
    localparam logic [OW-1:0] OP_SRL   = 4'hE;
    localparam logic [OW-1:0] OP_SRA   = 4'hF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] ALUOpsel = '0;
    logic [DW-1:0] opA = '0;
    logic [DW-1:0] opB = '0;
    logic [AW-1:0] opaddrA = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] ALUResult;
    logic [DW-1:0] ALUResultHi;
    logic          cout;
    logic          zero;
    logic          ovf;
    logic [1:0]    dbgState;

    int nVec = 0;
    int nMis = 0;

    seq_alu #(.D_WIDTH(DW), .OP_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOpsel(ALUOpsel), .opA(opA), .opB(opB), .opaddrA(opaddrA),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .ALUResultHi(ALUResultHi),
        .cout(cout), .zero(zero), .ovf(ovf), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] addr;
        logic [DW-1:0] res;
        logic          c;
        logic          z;
        logic          v;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack(input logic v, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                                           input logic c, input logic z, input logic o);
        return {v, lo, hi, c, z, o};
    endfunction

    function automatic logic [RW-1:0] outs();
        return pack(out_valid, ALUResult, ALUResultHi, cout, zero, ovf);
    endfunction

    // Accept edge counts as edge 1, so the result must appear DW edges later.
    task automatic runLong(input string name, input logic [OW-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                           input logic [1:0] busyState);
        int k;
        logic sawReady;
        @(negedge clk);
        in_valid = 1'b1; ALUOpsel = op; opA = a; opB = b; out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_busy"}, {in_ready, out_valid, dbgState}, {1'b0, 1'b0, busyState});
        @(negedge clk);
        ALUOpsel = OP_ADD; opA = $urandom; opB = $urandom;
        sawReady = 1'b0;
        k = 0;
        while (k < DW + 8) begin
            @(posedge clk); #1;
            k++;
            if (out_valid) break;
            if (in_ready) sawReady = 1'b1;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, k, DW);
        check({name, "_ready_low"}, sawReady, 1'b0);
        check({name, "_result"}, outs(), pack(1'b1, lo, hi, 1'b0, lo == '0, 1'b0));
    endtask

    initial begin
        int sawValid;

        vecs.push_back('{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 6'h00, 32'h00000000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 6'h00, 32'h80000000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_ADD,   32'h00000003, 32'h00000004, 6'h00, 32'h00000007, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SUB,   32'h80000000, 32'h00000001, 6'h00, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_SUB,   32'h00000001, 32'h00000002, 6'h00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{OP_SUB,   32'h00000005, 32'h00000005, 6'h00, 32'h00000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 6'h00, 32'hF000F000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_OR,    32'hF0F0F0F0, 32'h0F0F0000, 6'h00, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_XOR,   32'hAAAAAAAA, 32'hFFFFFFFF, 6'h00, 32'h55555555, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_NOTA,  32'h00000000, 32'h00001234, 6'h00, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SLL,   32'h00000001, 32'h00000021, 6'h00, 32'h00000002, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SRL,   32'h80000000, 32'h00000004, 6'h00, 32'h08000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SRA,   32'h80000000, 32'h00000004, 6'h00, 32'hF8000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SRA,   32'h40000000, 32'h0000001E, 6'h00, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_PASSA, 32'hDEADBEEF, 32'h00000000, 6'h00, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_ADDR0, 32'h12345678, 32'h00000000, 6'h3F, 32'h0000003F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_ADDR1, 32'h12345678, 32'h00000000, 6'h2A, 32'h0000002A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 6'h00, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SLT,   32'h00000001, 32'hFFFFFFFF, 6'h00, 32'h00000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{OP_UNDEF, 32'h12345678, 32'h87654321, 6'h11, 32'h00000000, 1'b0, 1'b1, 1'b0});
`ifndef SEQ_ALU_DIV_EN
        vecs.push_back('{OP_DIVU,  32'h00000064, 32'h00000007, 6'h00, 32'h00000000, 1'b0, 1'b1, 1'b0});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {outs(), dbgState}, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", in_ready, 1'b1);

        // Single-cycle vectors back to back: one result per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1; ALUOpsel = vecs[i].op; opA = vecs[i].a; opB = vecs[i].b;
            opaddrA = vecs[i].addr; out_ready = 1'b1;
            @(posedge clk); #1;
            check($sformatf("vec%0d_op%h", i, vecs[i].op), {in_ready, outs()},
                  {1'b1, pack(1'b1, vecs[i].res, '0, vecs[i].c, vecs[i].z, vecs[i].v)});
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_valid_low", out_valid, 1'b0);

        // Backpressure: ADD 3+4 held for 5 cycles with a competing request present
        @(negedge clk);
        in_valid = 1'b1; ALUOpsel = OP_ADD; opA = 32'd3; opB = 32'd4; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        opA = 32'd1; opB = 32'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_cycle%0d", k), {in_ready, outs()},
                  {1'b0, pack(1'b1, 32'd7, '0, 1'b0, 1'b0, 1'b0)});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("release", {out_valid, in_ready}, 2'b01);

        // Multi-cycle operations
        runLong("mulu_max", OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 2'd1);
        runLong("mulu_shift", OP_MULU, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 2'd1);
        runLong("mulu_zero", OP_MULU, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 2'd1);
        runLong("mulu_small", OP_MULU, 32'h00000007, 32'h00000006, 32'h0000002A, 32'h00000000, 2'd1);
`ifdef SEQ_ALU_DIV_EN
        runLong("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 2'd2);
        runLong("divu_by_zero", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 2'd2);
        runLong("divu_by_one", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 2'd2);
`endif

        // Reset mid-multiply: asynchronous clear, no result afterwards
        @(negedge clk);
        in_valid = 1'b1; ALUOpsel = OP_MULU; opA = 32'hFFFFFFFF; opB = 32'hFFFFFFFF; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_mul", {outs(), dbgState}, '0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 0;
        for (int k = 0; k < DW + 4; k++) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1;
        end
        check("no_result_after_reset", sawValid, 0);

        @(negedge clk);
        in_valid = 1'b1; ALUOpsel = OP_ADD; opA = 32'd1; opB = 32'd1;
        @(posedge clk); #1;
        check("add_after_reset", outs(), pack(1'b1, 32'd2, '0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
